// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the matrix scanner and its consumers.
// The scanner drives rows and key events; the keypad side drives the column lines.
interface keypad_scanner_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  col_n,
        output row_n,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output col_n,
        input  row_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low row at a time, synchronizes the
// columns, debounces a single press/release and emits one hex code per press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 48000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] PRESS_DB = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] REL_DB   = 2'd3;

    logic [3:0]       col_meta;
    logic [3:0]       col_s;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [1:0]       state;
    logic [1:0]       r;
    logic [1:0]       c;
    logic [1:0]       c_low;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_nxt;
    logic             deb_done;
    logic [3:0]       key_code;
    logic             key_valid;
    logic             key_held;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] k;
        case ({row, col})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign tick     = (div == DIV_W'(SCAN_DIV - 1));
    assign deb_nxt  = deb_cnt + DEB_W'(1);
    assign deb_done = (deb_nxt == DEB_W'(DEBOUNCE_TICKS));

    // Lowest-index low column wins when several keys in the row are down.
    always_comb begin
        c_low = 2'd3;
        if (!col_s[0])      c_low = 2'd0;
        else if (!col_s[1]) c_low = 2'd1;
        else if (!col_s[2]) c_low = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_meta  <= 4'hF;
            col_s     <= 4'hF;
            div       <= '0;
            state     <= SCAN;
            r         <= 2'd0;
            c         <= 2'd0;
            deb_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            col_meta  <= kp.col_n;
            col_s     <= col_meta;
            div       <= tick ? '0 : div + DIV_W'(1);
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (col_s != 4'hF) begin
                            c       <= c_low;
                            deb_cnt <= DEB_W'(1);
                            if (DEBOUNCE_TICKS == 1) begin
                                key_code  <= key_map(r, c_low);
                                key_held  <= 1'b1;
                                key_valid <= 1'b1;
                                state     <= HELD;
                            end else begin
                                state <= PRESS_DB;
                            end
                        end else begin
                            r <= r + 2'd1;
                        end
                    end
                    PRESS_DB: begin
                        if (!col_s[c]) begin
                            deb_cnt <= deb_nxt;
                            if (deb_done) begin
                                key_code  <= key_map(r, c);
                                key_held  <= 1'b1;
                                key_valid <= 1'b1;
                                state     <= HELD;
                            end
                        end else begin
                            // Bounce: drop the candidate silently and move on.
                            r     <= r + 2'd1;
                            state <= SCAN;
                        end
                    end
                    HELD: begin
                        if (col_s[c]) begin
                            deb_cnt <= DEB_W'(1);
                            if (DEBOUNCE_TICKS == 1) begin
                                key_held <= 1'b0;
                                r        <= r + 2'd1;
                                state    <= SCAN;
                            end else begin
                                state <= REL_DB;
                            end
                        end
                    end
                    default: begin
                        if (col_s[c]) begin
                            deb_cnt <= deb_nxt;
                            if (deb_done) begin
                                key_held <= 1'b0;
                                r        <= r + 2'd1;
                                state    <= SCAN;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                endcase
            end
        end
    end

    assign kp.row_n     = ~(4'b0001 << r);
    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized checks of keypad_scanner against a keypad short model
// and a key-map / scan-order reference derived from the keypad layout.
module tb_keypad_scanner;
    logic clk;
    logic reset;
    logic [3:0][3:0] pressed;
    logic [3:0] col_drv;
    int n_checks;
    int n_fail;
    int pulses;
    logic prev_valid;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: the active (low) row shorts every pressed key onto its column.
    always_comb begin
        col_drv = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (pressed[rr][cc] && !kp.row_n[rr]) col_drv[cc] = 1'b0;
    end
    assign kp.col_n = col_drv;

    function automatic logic [3:0] ref_key(input int row, input int col);
        logic [3:0] tbl [16];
        tbl = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        return tbl[row * 4 + col];
    endfunction

    function automatic logic [3:0] row_drive(input int row);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << row);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (kp.key_valid === 1'b1) pulses++;
        check("valid_single_cycle", 32'(prev_valid & kp.key_valid), 0);
        check("row_one_low", 32'($countones(~kp.row_n)), 1);
        prev_valid = kp.key_valid;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin step(); n++; end while (kp.key_valid !== 1'b1 && n < 200);
        check(tag, 32'(kp.key_valid), 1);
    endtask

    task automatic wait_release(input string tag, output int n);
        n = 0;
        do begin step(); n++; end while (kp.key_held !== 1'b0 && n < 200);
        check(tag, 32'(kp.key_held), 0);
    endtask

    task automatic wait_row(input logic [3:0] rn, input string tag);
        int n;
        n = 0;
        do begin step(); n++; end while (kp.row_n !== rn && n < 100);
        check(tag, 32'(kp.row_n), 32'(rn));
    endtask

    initial begin
        int n;
        int base;
        bit seen_row3;
        bit held_dropped;
        n_checks = 0; n_fail = 0; pulses = 0; prev_valid = 1'b0;
        pressed = '0;
        reset = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_row_n", 32'(kp.row_n), 32'(4'b1110));
        check("rst_code", 32'(kp.key_code), 0);
        check("rst_valid", 32'(kp.key_valid), 0);
        check("rst_held", 32'(kp.key_held), 0);

        // Idle scan order, one row every 4 clocks
        reset = 1'b0;
        check("scan_k0", 32'(kp.row_n), 32'(4'b1110));
        for (int k = 1; k <= 16; k++) begin
            step();
            check("scan_order", 32'(kp.row_n), 32'(row_drive((k / 4) % 4)));
        end

        // Key 5 held steady, then released
        pressed[1][1] = 1'b1;
        wait_valid("k5_valid");
        check("k5_code", 32'(kp.key_code), 32'h5);
        check("k5_held", 32'(kp.key_held), 1);
        base = pulses;
        repeat (40) step();
        check("k5_one_pulse", 32'(pulses - base), 0);
        check("k5_row_frozen", 32'(kp.row_n), 32'(4'b1101));
        check("k5_still_held", 32'(kp.key_held), 1);
        pressed[1][1] = 1'b0;
        wait_release("k5_release", n);
        check("k5_release_latency", 32'(n >= 11 && n <= 14), 1);
        check("k5_resume_row2", 32'(kp.row_n), 32'(4'b1011));
        check("k5_code_kept", 32'(kp.key_code), 32'h5);

        // Key 9 bounces for exactly one tick
        wait_row(4'b0111, "b9_sync_row3");
        wait_row(4'b1011, "b9_sync_row2");
        base = pulses;
        pressed[2][2] = 1'b1;
        repeat (4) step();
        pressed[2][2] = 1'b0;
        seen_row3 = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (kp.row_n == 4'b0111) seen_row3 = 1'b1;
            if (kp.key_held !== 1'b0) held_dropped = 1'b1;
        end
        check("b9_no_pulse", 32'(pulses - base), 0);
        check("b9_not_held", 32'(kp.key_held), 0);
        check("b9_scanning", 32'(seen_row3), 1);

        // Hold 5, add A: A ignored until 5 released, then picked up on row 0
        pressed[1][1] = 1'b1;
        wait_valid("k5a_valid");
        check("k5a_code", 32'(kp.key_code), 32'h5);
        base = pulses;
        pressed[0][3] = 1'b1;
        repeat (40) step();
        check("k5a_no_second", 32'(pulses - base), 0);
        check("k5a_code_kept", 32'(kp.key_code), 32'h5);
        pressed[1][1] = 1'b0;
        wait_release("k5a_release", n);
        base = pulses;
        wait_valid("kA_valid");
        check("kA_code", 32'(kp.key_code), 32'hA);
        check("kA_held", 32'(kp.key_held), 1);
        check("kA_row0", 32'(kp.row_n), 32'(4'b1110));
        repeat (20) step();
        check("kA_one_pulse", 32'(pulses - base), 1);
        pressed[0][3] = 1'b0;
        wait_release("kA_release", n);

        // Key D with a one-tick open during release debounce
        pressed[3][3] = 1'b1;
        wait_valid("kD_valid");
        check("kD_code", 32'(kp.key_code), 32'hD);
        base = pulses;
        repeat (4) step();
        pressed[3][3] = 1'b0;
        repeat (4) step();
        pressed[3][3] = 1'b1;
        held_dropped = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (kp.key_held !== 1'b1) held_dropped = 1'b1;
        end
        check("kD_held_through", 32'(held_dropped), 0);
        check("kD_no_new_pulse", 32'(pulses - base), 0);
        pressed[3][3] = 1'b0;
        wait_release("kD_release", n);

        // Keys 4 and 6 together, then reset while held
        pressed[1][0] = 1'b1;
        pressed[1][2] = 1'b1;
        wait_valid("k46_valid");
        check("k46_code", 32'(kp.key_code), 32'h4);
        repeat (5) step();
        base = pulses;
        reset = 1'b1;
        step();
        check("mid_rst_row_n", 32'(kp.row_n), 32'(4'b1110));
        check("mid_rst_held", 32'(kp.key_held), 0);
        check("mid_rst_code", 32'(kp.key_code), 0);
        check("mid_rst_valid", 32'(kp.key_valid), 0);
        pressed = '0;
        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();
        check("mid_rst_no_pulse", 32'(pulses - base), 0);

        // Randomized single presses against the key map
        for (int it = 0; it < 10; it++) begin
            int row;
            int col;
            row = int'($urandom_range(3, 0));
            col = int'($urandom_range(3, 0));
            repeat ($urandom_range(20, 0)) step();
            base = pulses;
            pressed[row][col] = 1'b1;
            wait_valid("rnd_valid");
            check("rnd_code", 32'(kp.key_code), 32'(ref_key(row, col)));
            check("rnd_row", 32'(kp.row_n), 32'(row_drive(row)));
            repeat ($urandom_range(30, 0)) step();
            check("rnd_held", 32'(kp.key_held), 1);
            pressed[row][col] = 1'b0;
            wait_release("rnd_release", n);
            check("rnd_next_row", 32'(kp.row_n), 32'(row_drive((row + 1) % 4)));
            check("rnd_one_pulse", 32'(pulses - base), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
